// File: rtl/rv_regfile.sv
// rv_regfile: RV64 integer register file, NUM_REGS x ARCH_WIDTH, two combinational read ports, one write port.
// Optional REGFILE_INDEX_RESET_EN: register i resets to value i (x0 always 0); otherwise all reset to 0.

module register #(
    parameter int                    ARCH_WIDTH = 64,
    parameter logic [ARCH_WIDTH-1:0] START_VAL  = {ARCH_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  writeEnable,
    input  logic [ARCH_WIDTH-1:0] writeData,
    input  logic                  readOnly,
    output logic [ARCH_WIDTH-1:0] readData
);
    logic [ARCH_WIDTH-1:0] data_r;

    // Storage cell; read-only cells never take a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= START_VAL;
        end else if (writeEnable && !readOnly) begin
            data_r <= writeData;
        end else begin
            data_r <= data_r;
        end
    end

    // Read-only cells present a constant zero
    always_comb begin
        if (readOnly) begin
            readData = {ARCH_WIDTH{1'b0}};
        end else begin
            readData = data_r;
        end
    end
endmodule

module mux #(
    parameter int INPUT_QUANTITY = 32,
    parameter int ARCH_WIDTH     = 64,
    parameter int SEL_WIDTH      = 5
) (
    input  logic [INPUT_QUANTITY-1:0][ARCH_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]                      sel,
    output logic [ARCH_WIDTH-1:0]                     out_data
);
    // Combinational INPUT_QUANTITY:1 selector
    always_comb begin
        out_data = in_data[sel];
    end
endmodule

module rv_regfile #(
    parameter int ARCH_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int SEL_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEL_WIDTH-1:0]  rs1,
    input  logic [SEL_WIDTH-1:0]  rs2,
    input  logic [SEL_WIDTH-1:0]  rd,
    input  logic                  wEn,
    input  logic                  immediate,
    input  logic [ARCH_WIDTH-1:0] wData,
    output logic [ARCH_WIDTH-1:0] out1,
    output logic [ARCH_WIDTH-1:0] out2
);
    logic [NUM_REGS-1:0]                 we_s;
    logic [NUM_REGS-1:0][ARCH_WIDTH-1:0] rdata_s;
    logic [ARCH_WIDTH-1:0]               mux2_s;

    // One-hot write-enable decode from rd
    always_comb begin
        we_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            we_s[i] = wEn && (rd == SEL_WIDTH'(i));
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
`ifdef REGFILE_INDEX_RESET_EN
        localparam logic [ARCH_WIDTH-1:0] RST_VAL = (i == 0) ? {ARCH_WIDTH{1'b0}} : ARCH_WIDTH'(i);
`else
        localparam logic [ARCH_WIDTH-1:0] RST_VAL = {ARCH_WIDTH{1'b0}};
`endif
        register #(
            .ARCH_WIDTH(ARCH_WIDTH),
            .START_VAL (RST_VAL)
        ) u_reg (
            .clk        (clk),
            .rst_n      (rst_n),
            .writeEnable(we_s[i]),
            .writeData  (wData),
            .readOnly   ((i == 0) ? 1'b1 : 1'b0),
            .readData   (rdata_s[i])
        );
    end

    mux #(
        .INPUT_QUANTITY(NUM_REGS),
        .ARCH_WIDTH    (ARCH_WIDTH),
        .SEL_WIDTH     (SEL_WIDTH)
    ) u_mux1 (
        .in_data (rdata_s),
        .sel     (rs1),
        .out_data(out1)
    );

    mux #(
        .INPUT_QUANTITY(NUM_REGS),
        .ARCH_WIDTH    (ARCH_WIDTH),
        .SEL_WIDTH     (SEL_WIDTH)
    ) u_mux2 (
        .in_data (rdata_s),
        .sel     (rs2),
        .out_data(mux2_s)
    );

    // Immediate-form instructions take no second register operand
    always_comb begin
        if (immediate) begin
            out2 = {ARCH_WIDTH{1'b0}};
        end else begin
            out2 = mux2_s;
        end
    end
endmodule

// File: tb/tb_rv_regfile.sv
// Self-checking bench for rv_regfile: reference register model feeds a scoreboard queue of expected reads.
`timescale 1ns/100ps

module tb_rv_regfile;
    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        wEn, immediate;
    logic [63:0] wData, out1, out2;

    logic [63:0] model [32];
    logic [63:0] exp_q [$];
    logic [63:0] e1, e2;
    int          checks;
    int          errors;

    rv_regfile dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd(rd), .wEn(wEn),
        .immediate(immediate), .wData(wData), .out1(out1), .out2(out2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] reset_val(input int i);
`ifdef REGFILE_INDEX_RESET_EN
        if (i == 0) return 64'd0;
        else return 64'(i);
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = reset_val(i);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [63:0] d, input logic en);
        @(negedge clk);
        rd = a; wData = d; wEn = en;
        @(posedge clk);
        if (rst_n && en && a != 5'd0) model[a] = d;
        #1 wEn = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #0.5;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            exp_q.push_back(model[i]); exp_q.push_back(model[31 - i]);
            #0.1;
            e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
            checks += 2;
            if (out1 !== e1) begin errors++; $display("FAIL reset_out1 rs1=%0d got %h want %h", i, out1, e1); end
            if (out2 !== e2) begin errors++; $display("FAIL reset_out2 rs2=%0d got %h want %h", 31 - i, out2, e2); end
        end
        do_write(5'd4, 64'hCAFE_0000_0000_0004, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(5'd1, 64'h1111_2222_3333_4444, 1'b1);
        @(negedge clk);
        rs1 = 5'd1; rs2 = 5'd4;
        exp_q.push_back(64'h1111_2222_3333_4444); exp_q.push_back(reset_val(4));
        #0.5;
        e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
        checks += 2;
        if (out1 !== e1) begin errors++; $display("FAIL first_write_after_reset got %h want %h", out1, e1); end
        if (out2 !== e2) begin errors++; $display("FAIL write_during_reset got %h want %h", out2, e2); end
    endtask

    task automatic sweep_all(input string tag);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            exp_q.push_back(model[i]); exp_q.push_back(model[31 - i]);
            #0.1;
            e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
            checks += 2;
            if (out1 !== e1) begin errors++; $display("FAIL %s_out1 rs1=%0d got %h want %h", tag, i, out1, e1); end
            if (out2 !== e2) begin errors++; $display("FAIL %s_out2 rs2=%0d got %h want %h", tag, 31 - i, out2, e2); end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        rd = 5'd5; wData = 64'hDEAD_BEEF_0123_4567; wEn = 1'b1;
        rs1 = 5'd5; rs2 = 5'd5;
        exp_q.push_back(model[5]);
        #1;
        e1 = exp_q.pop_front();
        checks += 2;
        if (out1 !== e1) begin errors++; $display("FAIL no_bypass_out1 got %h want %h", out1, e1); end
        if (out2 !== e1) begin errors++; $display("FAIL no_bypass_out2 got %h want %h", out2, e1); end
        @(posedge clk);
        model[5] = 64'hDEAD_BEEF_0123_4567;
        exp_q.push_back(model[5]);
        #1 wEn = 1'b0;
        e1 = exp_q.pop_front();
        checks += 2;
        if (out1 !== e1) begin errors++; $display("FAIL write_read_out1 got %h want %h", out1, e1); end
        if (out2 !== e1) begin errors++; $display("FAIL write_read_out2 got %h want %h", out2, e1); end
        sweep_all("write_read");
    endtask

    task automatic test_x0();
        do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        sweep_all("x0_protect");
    endtask

    task automatic test_wen_gating();
        do_write(5'd7, 64'h7777_0000_7777_0000, 1'b1);
        for (int k = 0; k < 4; k++) do_write(5'd7, 64'h55, 1'b0);
        @(negedge clk);
        rs1 = 5'd7;
        exp_q.push_back(64'h7777_0000_7777_0000);
        #0.5;
        e1 = exp_q.pop_front();
        checks++;
        if (out1 !== e1) begin errors++; $display("FAIL wen_gating got %h want %h", out1, e1); end
    endtask

    task automatic test_immediate();
        do_write(5'd3, 64'h1234, 1'b1);
        @(negedge clk);
        rs1 = 5'd3; rs2 = 5'd3; immediate = 1'b1;
        exp_q.push_back(64'h1234); exp_q.push_back(64'd0);
        #0.5;
        e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
        checks += 2;
        if (out1 !== e1) begin errors++; $display("FAIL imm_out1 got %h want %h", out1, e1); end
        if (out2 !== e2) begin errors++; $display("FAIL imm_out2_forced got %h want %h", out2, e2); end
        immediate = 1'b0;
        exp_q.push_back(64'h1234);
        #0.5;
        e2 = exp_q.pop_front();
        checks++;
        if (out2 !== e2) begin errors++; $display("FAIL imm_released_out2 got %h want %h", out2, e2); end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k < 32; k++) do_write(5'(k), {$urandom(), $urandom()}, 1'b1);
        sweep_all("back_to_back");
    endtask

    task automatic test_async_reset();
        do_write(5'd10, 64'hFF, 1'b1);
        rs1 = 5'd10;
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        exp_q.push_back(reset_val(10));
        #0.5;
        e1 = exp_q.pop_front();
        checks++;
        if (out1 !== e1) begin errors++; $display("FAIL async_reset_x10 got %h want %h", out1, e1); end
        do_write(5'd10, 64'hAB, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_all("async_reset");
    endtask

    initial begin
        checks = 0; errors = 0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; wEn = 1'b0; immediate = 1'b0; wData = 64'd0;
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_x0();
        test_wen_gating();
        test_immediate();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
